// File: rtl/rocketcpu_ram_arbiter_pkg.sv
// rtl/rocketcpu_ram_arbiter_pkg.sv - shared widths, FSM encoding and helpers for the SPRAM arbiter
package rocketcpu_ram_arbiter_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rocketcpu_rr_picker.sv
// rtl/rocketcpu_rr_picker.sv - combinational round-robin picker: first requester at or after ptr
module rocketcpu_rr_picker #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[(int'(ptr) + i) % N]) begin
        any                         = 1'b1;
        gnt[(int'(ptr) + i) % N]    = 1'b1;
        idx                         = IW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/rocketcpu_ram_arbiter.sv
// rtl/rocketcpu_ram_arbiter.sv - round-robin Wishbone arbiter in front of the single-port SPRAM
module rocketcpu_ram_arbiter
  import rocketcpu_ram_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 3,
  parameter int TIMEOUT   = 15,
  parameter int SLAVE_LAT = 2
) (
  input  logic                       i_wb_clk,
  input  logic                       i_wb_rst_n,
  input  logic [WB_AW*N_MASTERS-1:0] i_m_adr,
  input  logic [WB_DW*N_MASTERS-1:0] i_m_dat,
  input  logic [WB_SW*N_MASTERS-1:0] i_m_sel,
  input  logic [N_MASTERS-1:0]       i_m_we,
  input  logic [N_MASTERS-1:0]       i_m_cyc,
  output logic [WB_DW-1:0]           o_m_rdt,
  output logic [N_MASTERS-1:0]       o_m_ack,
  output logic [N_MASTERS-1:0]       o_m_err,
  output logic [WB_AW-1:0]           o_s_adr,
  output logic [WB_DW-1:0]           o_s_dat,
  output logic [WB_SW-1:0]           o_s_sel,
  output logic                       o_s_we,
  output logic                       o_s_cyc,
  input  logic [WB_DW-1:0]           i_s_rdt,
  input  logic                       i_s_ack
);

  localparam int IW = $clog2(N_MASTERS);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int CW = $clog2(SLAVE_LAT) + 1;

  state_t               state, state_d;
  logic [N_MASTERS-1:0] grant, grant_d;
  logic [IW-1:0]        gidx, gidx_d;
  logic [IW-1:0]        rr_ptr, rr_ptr_d;
  logic [TW-1:0]        timer, timer_d;
  logic [CW-1:0]        drain_cnt, drain_d;

  logic [N_MASTERS-1:0] pick_gnt;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;

  rocketcpu_rr_picker #(
    .N  (N_MASTERS),
    .IW (IW)
  ) u_picker (
    .req (i_m_cyc),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state     <= ST_IDLE;
      grant     <= '0;
      gidx      <= '0;
      rr_ptr    <= '0;
      timer     <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_d;
      grant     <= grant_d;
      gidx      <= gidx_d;
      rr_ptr    <= rr_ptr_d;
      timer     <= timer_d;
      drain_cnt <= drain_d;
    end
  end

  always_comb begin
    state_d  = state;
    grant_d  = grant;
    gidx_d   = gidx;
    rr_ptr_d = rr_ptr;
    timer_d  = timer;
    drain_d  = drain_cnt;
    o_s_cyc  = 1'b0;
    o_s_adr  = '0;
    o_s_dat  = '0;
    o_s_sel  = '0;
    o_s_we   = 1'b0;
    o_m_rdt  = '0;
    o_m_ack  = '0;
    o_m_err  = '0;

    case (state)
      ST_IDLE: begin
        timer_d = '0;
        if (pick_any) begin
          grant_d  = pick_gnt;
          gidx_d   = pick_idx;
          rr_ptr_d = IW'(wrap_inc(int'(pick_idx), N_MASTERS));
          state_d  = ST_BUSY;
        end
      end

      ST_BUSY: begin
        // A master that drops cyc takes the slave cycle down with it in the same cycle.
        o_s_cyc = i_m_cyc[gidx];
        o_s_adr = i_m_adr[int'(gidx)*WB_AW +: WB_AW];
        o_s_dat = i_m_dat[int'(gidx)*WB_DW +: WB_DW];
        o_s_sel = i_m_sel[int'(gidx)*WB_SW +: WB_SW];
        o_s_we  = i_m_we[gidx];
        o_m_rdt = i_s_rdt;
        timer_d = timer + TW'(1);
        if (i_s_ack) begin
          o_m_ack = grant;
          timer_d = '0;
          state_d = ST_IDLE;
        end else if (!i_m_cyc[gidx]) begin
          timer_d = '0;
          drain_d = '0;
          state_d = ST_DRAIN;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          o_m_err = grant;
          timer_d = '0;
          drain_d = '0;
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // Late acks from the abandoned cycle land here and are dropped.
        drain_d = drain_cnt + CW'(1);
        if (drain_cnt == CW'(SLAVE_LAT - 1)) begin
          drain_d = '0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rocketcpu_ram_arbiter.sv
// tb/tb_rocketcpu_ram_arbiter.sv - scoreboard bench with round-robin reference model for the SPRAM arbiter
module tb_rocketcpu_ram_arbiter;

  localparam int NM = 3;
  localparam int TO = 15;
  localparam int SL = 2;
  localparam int K_ACK   = 0;
  localparam int K_ERR   = 1;
  localparam int K_ABORT = 2;

  typedef struct {
    int          m;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    int          kind;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [32*NM-1:0] i_m_adr, i_m_dat;
  logic [4*NM-1:0]  i_m_sel;
  logic [NM-1:0]    i_m_we, i_m_cyc;
  logic [31:0]      o_m_rdt;
  logic [NM-1:0]    o_m_ack, o_m_err;
  logic [31:0]      o_s_adr, o_s_dat;
  logic [3:0]       o_s_sel;
  logic             o_s_we, o_s_cyc;
  logic [31:0]      i_s_rdt;
  logic             i_s_ack;

  logic [31:0] mst_adr [NM] = '{default: '0};
  logic [31:0] mst_dat [NM] = '{default: '0};
  logic [3:0]  mst_sel [NM] = '{default: '0};
  logic        mst_we  [NM] = '{default: 1'b0};
  int          req_seq [NM] = '{default: 0};
  int          done_seq[NM] = '{default: 0};
  int          kill_seq[NM] = '{default: 0};

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   cycle = 0;
  int   model_ptr = 0;
  int   raise_cycle = 0;
  int   inject_req = 0;
  int   inject_done = 0;
  int   last_end = -1;
  int   last_gap = -1;
  logic slave_mute = 1'b0;
  logic mon_en = 1'b0;

  rocketcpu_ram_arbiter #(
    .N_MASTERS (NM),
    .TIMEOUT   (TO),
    .SLAVE_LAT (SL)
  ) dut (
    .i_wb_clk   (clk),
    .i_wb_rst_n (rst_n),
    .i_m_adr    (i_m_adr),
    .i_m_dat    (i_m_dat),
    .i_m_sel    (i_m_sel),
    .i_m_we     (i_m_we),
    .i_m_cyc    (i_m_cyc),
    .o_m_rdt    (o_m_rdt),
    .o_m_ack    (o_m_ack),
    .o_m_err    (o_m_err),
    .o_s_adr    (o_s_adr),
    .o_s_dat    (o_s_dat),
    .o_s_sel    (o_s_sel),
    .o_s_we     (o_s_we),
    .o_s_cyc    (o_s_cyc),
    .i_s_rdt    (i_s_rdt),
    .i_s_ack    (i_s_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  always_comb begin
    i_m_adr = '0;
    i_m_dat = '0;
    i_m_sel = '0;
    i_m_we  = '0;
    i_m_cyc = '0;
    for (int k = 0; k < NM; k++) begin
      i_m_adr[32*k +: 32] = mst_adr[k];
      i_m_dat[32*k +: 32] = mst_dat[k];
      i_m_sel[4*k +: 4]   = mst_sel[k];
      i_m_we[k]           = mst_we[k];
      i_m_cyc[k]          = (req_seq[k] - done_seq[k] - kill_seq[k]) != 0;
    end
  end

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=0x%08h required=0x%08h at t=%0t", name, act, req, $time);
    end
  endtask

  // SPRAM-like slave: acks on the third BUSY cycle, i.e. two cycles after o_s_cyc rises.
  initial begin : slave
    int scnt;
    scnt    = 0;
    i_s_ack = 1'b0;
    i_s_rdt = '0;
    forever begin
      @(posedge clk); #1;
      i_s_ack = 1'b0;
      if (inject_req != inject_done) begin
        i_s_ack = 1'b1;
        i_s_rdt = 32'hDEAD_BEEF;
        inject_done++;
      end else if (o_s_cyc && !slave_mute) begin
        scnt++;
        if (scnt == SL + 1) begin
          i_s_ack = 1'b1;
          i_s_rdt = rd_model(o_s_adr);
        end
      end else begin
        scnt = 0;
      end
    end
  end

  initial begin : monitor
    exp_t          e;
    logic [NM-1:0] resp;
    int            drop_m, busy_start, min_gap, ridx;
    logic          active;
    drop_m = -1; busy_start = 0; min_gap = 0; active = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (drop_m >= 0) begin
        done_seq[drop_m]++;
        drop_m = -1;
      end
      @(negedge clk);
      if (!mon_en || !rst_n) begin
        active   = 1'b0;
        last_end = -1;
        drop_m   = -1;
      end else begin
        resp = o_m_ack | o_m_err;
        if (o_s_cyc && !active) begin
          if (exp_q.size() == 0) chk("slave_cycle_without_request", 32'(o_s_cyc), 0);
          else begin
            active     = 1'b1;
            busy_start = cycle;
            if (last_end >= 0) begin
              last_gap = cycle - last_end;
              chk("idle_gap_min", last_gap, (last_gap >= min_gap) ? last_gap : min_gap);
            end
          end
        end
        if (o_s_cyc && active) begin
          chk("s_adr", o_s_adr, exp_q[0].adr);
          chk("s_dat", o_s_dat, exp_q[0].dat);
          chk("s_sel", 32'(o_s_sel), 32'(exp_q[0].sel));
          chk("s_we", 32'(o_s_we), 32'(exp_q[0].we));
        end
        if ((o_m_ack & o_m_err) != '0) chk("ack_err_overlap", 32'(o_m_ack & o_m_err), 0);
        if (resp != '0) begin
          if (!active) chk("response_outside_txn", 32'(resp), 0);
          else begin
            e    = exp_q.pop_front();
            ridx = -1;
            for (int k = 0; k < NM; k++) if (resp[k]) ridx = k;
            chk("resp_onehot", $countones(resp), 1);
            chk("resp_master", ridx, e.m);
            chk("resp_kind", (o_m_err != '0) ? K_ERR : K_ACK, e.kind);
            if (e.kind == K_ACK) begin
              chk("rdt", o_m_rdt, rd_model(e.adr));
              chk("ack_latency", cycle - busy_start, SL);
            end else begin
              chk("err_busy_cycles", cycle - busy_start + 1, TO);
            end
            active   = 1'b0;
            last_end = cycle;
            min_gap  = (e.kind == K_ACK) ? 2 : SL + 2;
            drop_m   = e.m;
          end
        end else if (active && !o_s_cyc) begin
          e = exp_q.pop_front();
          chk("silent_end_kind", e.kind, K_ABORT);
          active   = 1'b0;
          last_end = cycle;
          min_gap  = SL + 2;
        end
      end
    end
  end

  task automatic rand_fields(input logic [NM-1:0] mask);
    for (int k = 0; k < NM; k++) begin
      if (mask[k]) begin
        mst_adr[k] = $urandom;
        mst_dat[k] = $urandom;
        mst_sel[k] = 4'($urandom_range(1, 15));
        mst_we[k]  = 1'($urandom_range(0, 1));
      end
    end
  endtask

  // Reference order: repeatedly serve the first pending master at or after the pointer.
  task automatic issue_batch(input logic [NM-1:0] mask, input int first_kind);
    logic [NM-1:0] left;
    int            k;
    bit            first;
    exp_t          e;
    left  = mask;
    first = 1'b1;
    while (left != '0) begin
      k = -1;
      for (int i = 0; i < NM; i++)
        if (k < 0 && left[(model_ptr + i) % NM]) k = (model_ptr + i) % NM;
      e.m    = k;
      e.adr  = mst_adr[k];
      e.dat  = mst_dat[k];
      e.sel  = mst_sel[k];
      e.we   = mst_we[k];
      e.kind = first ? first_kind : K_ACK;
      exp_q.push_back(e);
      left[k]   = 1'b0;
      model_ptr = (k + 1) % NM;
      first     = 1'b0;
    end
    @(posedge clk); #2;
    raise_cycle = cycle;
    for (int i = 0; i < NM; i++) if (mask[i]) req_seq[i]++;
  endtask

  task automatic wait_idle(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && i_m_cyc == '0) break;
    end
    if (i == limit) begin
      chk("wait_idle_queue", exp_q.size(), 0);
      chk("wait_idle_cyc", 32'(i_m_cyc), 0);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1);
  end

  initial begin : stimulus
    int i;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_s_cyc", 32'(o_s_cyc), 0);
    chk("reset_m_ack", 32'(o_m_ack), 0);
    chk("reset_m_err", 32'(o_m_err), 0);
    chk("reset_s_adr", o_s_adr, 0);
    chk("reset_s_we", 32'(o_s_we), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Contention from reset: 0,1,2 then 0,1,2 again.
    rand_fields(3'b111);
    issue_batch(3'b111, K_ACK);
    wait_idle(200);
    chk("contention_gap", last_gap, 2);
    rand_fields(3'b111);
    issue_batch(3'b111, K_ACK);
    wait_idle(200);

    // Single read from master 1.
    mst_adr[1] = 32'h0000_0010; mst_we[1] = 1'b0; mst_sel[1] = 4'hF; mst_dat[1] = '0;
    issue_batch(3'b010, K_ACK);
    wait_idle(100);
    chk("read_ack_cycle", last_end - raise_cycle, 3);

    // Byte write from master 0.
    mst_adr[0] = 32'h0000_0124; mst_we[0] = 1'b1; mst_sel[0] = 4'b0100; mst_dat[0] = 32'hAABB_CCDD;
    issue_batch(3'b001, K_ACK);
    wait_idle(100);

    // Timeout on the first served master; the other waits and is served after DRAIN+IDLE.
    rand_fields(3'b101);
    slave_mute = 1'b1;
    issue_batch(3'b101, K_ERR);
    for (i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() <= 1) break;
    end
    if (i == 100) chk("timeout_err_seen", exp_q.size(), 1);
    slave_mute = 1'b0;
    wait_idle(100);
    chk("timeout_to_next_busy", last_gap, SL + 2);

    // Abort: master 2 drops cyc in its second BUSY cycle; slave acks during DRAIN.
    rand_fields(3'b100);
    issue_batch(3'b100, K_ABORT);
    repeat (2) @(posedge clk);
    #2;
    kill_seq[2]++;
    inject_req++;
    @(negedge clk); #1;
    chk("drain_ack_swallowed", 32'(o_m_ack), 0);
    chk("drain_s_cyc", 32'(o_s_cyc), 0);
    wait_idle(100);
    rand_fields(3'b010);
    issue_batch(3'b010, K_ACK);
    wait_idle(100);

    // Asynchronous reset while the ack is being returned.
    mon_en = 1'b0;
    rand_fields(3'b001);
    @(posedge clk); #2;
    req_seq[0]++;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_m_ack[0]) break;
    end
    chk("pre_reset_ack", 32'(o_m_ack), 1);
    chk("pre_reset_s_cyc", 32'(o_s_cyc), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_s_cyc", 32'(o_s_cyc), 0);
    chk("async_reset_m_ack", 32'(o_m_ack), 0);
    kill_seq[0]++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    model_ptr = 0;
    #1 mon_en = 1'b1;
    rand_fields(3'b111);
    issue_batch(3'b111, K_ACK);
    wait_idle(200);

    // Randomized request sets against the round-robin model.
    for (int n = 0; n < 40; n++) begin
      logic [NM-1:0] mask;
      mask = NM'($urandom_range(1, (1 << NM) - 1));
      rand_fields(mask);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      issue_batch(mask, K_ACK);
      wait_idle(300);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
